// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - ID lookup, EX resolve and perf-counter bundle for the branch predictor
interface branch_predictor_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  // ID-stage lookup
  logic             i_id_is_branch;
  logic [XLEN-1:0]  i_id_pc;
  logic             o_pred_taken;
  logic [XLEN-1:0]  o_pred_target;

  // EX-stage resolve / train
  logic             i_ex_valid;
  logic             i_ex_is_branch;
  logic             i_ex_update_en;
  logic [XLEN-1:0]  i_ex_pc;
  logic             i_ex_taken;
  logic [XLEN-1:0]  i_ex_target;
  logic             i_ex_pred_taken;
  logic [XLEN-1:0]  i_ex_pred_target;
  logic             o_is_pred_wrong;
  logic [XLEN-1:0]  o_redirect_pc;

  // Performance counters
  logic [CNT_W-1:0] o_br_cnt;
  logic [CNT_W-1:0] o_mispred_cnt;

  // Pipeline side: drives PCs and outcomes, consumes predictions
  modport master (
    output i_id_is_branch, i_id_pc,
    output i_ex_valid, i_ex_is_branch, i_ex_update_en, i_ex_pc,
    output i_ex_taken, i_ex_target, i_ex_pred_taken, i_ex_pred_target,
    input  o_pred_taken, o_pred_target, o_is_pred_wrong, o_redirect_pc,
    input  o_br_cnt, o_mispred_cnt
  );

  // Predictor side
  modport slave (
    input  i_id_is_branch, i_id_pc,
    input  i_ex_valid, i_ex_is_branch, i_ex_update_en, i_ex_pc,
    input  i_ex_taken, i_ex_target, i_ex_pred_taken, i_ex_pred_target,
    output o_pred_taken, o_pred_target, o_is_pred_wrong, o_redirect_pc,
    output o_br_cnt, o_mispred_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit saturating counters, ID lookup and EX training
module branch_predictor #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 6,
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  branch_predictor_if.slave    bus
);
  localparam int ENTRIES = 1 << IDX_W;

  // Table state; tag/target are only meaningful where valid_q is set
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [1:0]       cnt_q    [ENTRIES];

  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_q;

  // Lookup side (ID)
  logic [IDX_W-1:0] id_idx;
  logic [TAG_W-1:0] id_tag;
  logic             id_hit;

  // Resolve side (EX)
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             ex_br;
  logic             ex_train;
  logic             pred_wrong;

  // PC bits outside index/tag never affect the table
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.i_id_pc[1:0], bus.i_id_pc[XLEN-1:IDX_W+2+TAG_W],
                            bus.i_ex_pc[1:0], bus.i_ex_pc[XLEN-1:IDX_W+2+TAG_W]};

  assign id_idx = bus.i_id_pc[IDX_W+1:2];
  assign id_tag = bus.i_id_pc[IDX_W+2 +: TAG_W];
  assign ex_idx = bus.i_ex_pc[IDX_W+1:2];
  assign ex_tag = bus.i_ex_pc[IDX_W+2 +: TAG_W];

  // Lookup reads registered state only, so a same-cycle EX write is not seen here
  always_comb begin
    id_hit            = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
    bus.o_pred_taken  = bus.i_id_is_branch && id_hit && cnt_q[id_idx][1];
    bus.o_pred_target = target_q[id_idx];
  end

  // Resolve: mispredict is raised whenever EX holds a branch, stalled or not
  always_comb begin
    ex_br      = bus.i_ex_valid && bus.i_ex_is_branch;
    ex_train   = ex_br && bus.i_ex_update_en;
    ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    pred_wrong = ex_br && ((bus.i_ex_taken != bus.i_ex_pred_taken) ||
                           (bus.i_ex_taken && (bus.i_ex_target != bus.i_ex_pred_target)));
    bus.o_is_pred_wrong = pred_wrong;
    bus.o_redirect_pc   = bus.i_ex_taken ? bus.i_ex_target : bus.i_ex_pc + XLEN'(4);
  end

  // Table update; training is gated by the EX advance so a stalled branch trains once
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= 2'b01;
      end
    end else if (ex_train) begin
      if (ex_hit) begin
        if (bus.i_ex_taken) begin
          if (cnt_q[ex_idx] != 2'b11) cnt_q[ex_idx] <= cnt_q[ex_idx] + 2'b01;
          target_q[ex_idx] <= bus.i_ex_target;
        end else begin
          if (cnt_q[ex_idx] != 2'b00) cnt_q[ex_idx] <= cnt_q[ex_idx] - 2'b01;
        end
      end else if (bus.i_ex_taken) begin
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= bus.i_ex_target;
        cnt_q[ex_idx]    <= 2'b10;
      end
    end
  end

  // Saturating performance counters, stepped with training
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else if (ex_train) begin
      if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + CNT_W'(1);
      if (pred_wrong && (mispred_cnt_q != '1)) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
    end
  end

  assign bus.o_br_cnt      = br_cnt_q;
  assign bus.o_mispred_cnt = mispred_cnt_q;
endmodule
